// File: rtl/sap_ram_pkg.sv
// Shared widths, types and helpers for the SAP-1 style 16 x 8 RAM and its address register.
package sap_ram_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] word_t;

  localparam addr_t ADDR_ZERO = {ADDR_W{1'b0}};
  localparam word_t WORD_ZERO = {DATA_W{1'b0}};

  // Manual strobe is active-low, run-mode request is active-high; either one writes.
  function automatic logic write_request(input logic write_enable_n, input logic control);
    return (~write_enable_n) | control;
  endfunction

endpackage : sap_ram_pkg

// File: rtl/sap_mar.sv
// Memory address register: source mux, synchronous clear and active-low load.
module sap_mar
  import sap_ram_pkg::*;
(
  input  logic  clk_i,
  input  logic  clear_i,
  input  logic  load_n_i,
  input  logic  sel_dip_i,
  input  addr_t dip_addr_i,
  input  addr_t bus_addr_i,
  output addr_t mar_o
);

  addr_t mar_q;
  addr_t mar_d;
  addr_t src_addr;

  // Address source select and next-state; clear wins over load.
  always_comb begin
    src_addr = bus_addr_i;
    mar_d    = mar_q;
    if (sel_dip_i) begin
      src_addr = dip_addr_i;
    end else begin
      src_addr = bus_addr_i;
    end
    if (clear_i) begin
      mar_d = ADDR_ZERO;
    end else if (!load_n_i) begin
      mar_d = src_addr;
    end else begin
      mar_d = mar_q;
    end
  end

  // MAR register.
  always_ff @(posedge clk_i) begin
    mar_q <= mar_d;
  end

  assign mar_o = mar_q;

endmodule : sap_mar

// File: rtl/sap_ram.sv
// 16 x 8 SAP RAM: MAR sub-module, write-data mux, storage array and gated combinational read.
// Optional build macro SAP_RAM_CLEAR_ON_RESET_EN zeroes the whole array whenever clear_addr_reg is high.
module sap_ram
  import sap_ram_pkg::*;
(
  input  logic              clk,
  input  logic              clear_addr_reg,
  input  logic [DATA_W-1:0] dipswitch_data,
  input  logic [ADDR_W-1:0] dipswitch_addr,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              addr_button,
  input  logic              prog_mode,
  input  logic              load_addr_reg,
  input  logic              write_enable,
  input  logic              control_signal,
  input  logic              output_enable,
  output logic [DATA_W-1:0] bus_out
);

  addr_t mar;
  word_t wr_data;
  logic  wr_en;

  // Contents read as zero from power-up; reset never touches them unless the clear macro is set.
  word_t mem_q [DEPTH] = '{default: WORD_ZERO};

  sap_mar u_mar (
    .clk_i      (clk),
    .clear_i    (clear_addr_reg),
    .load_n_i   (load_addr_reg),
    .sel_dip_i  (addr_button),
    .dip_addr_i (dipswitch_addr),
    .bus_addr_i (bus_in[ADDR_W-1:0]),
    .mar_o      (mar)
  );

  // Write request decode and data source select.
  always_comb begin
    wr_en   = write_request(write_enable, control_signal);
    wr_data = dipswitch_data;
    if (prog_mode) begin
      wr_data = bus_in;
    end else begin
      wr_data = dipswitch_data;
    end
  end

  // Storage array; writes always use the MAR value held before the edge.
`ifdef SAP_RAM_CLEAR_ON_RESET_EN
  always_ff @(posedge clk) begin
    if (clear_addr_reg) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= WORD_ZERO;
      end
    end else if (wr_en) begin
      mem_q[mar] <= wr_data;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[mar] <= wr_data;
    end
  end
`endif

  // Read is combinational so a write is visible right after its edge.
  always_comb begin
    bus_out = WORD_ZERO;
    if (output_enable) begin
      bus_out = WORD_ZERO;
    end else begin
      bus_out = mem_q[mar];
    end
  end

endmodule : sap_ram

// File: tb/tb_sap_ram.sv
// Directed self-checking bench for sap_ram; expectations follow the clear-on-reset build macro.
module tb_sap_ram;

`ifdef SAP_RAM_CLEAR_ON_RESET_EN
  localparam bit CLR_MEM = 1'b1;
`else
  localparam bit CLR_MEM = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       clear_addr_reg;
  logic [7:0] dipswitch_data;
  logic [3:0] dipswitch_addr;
  logic [7:0] bus_in;
  logic       addr_button;
  logic       prog_mode;
  logic       load_addr_reg;
  logic       write_enable;
  logic       control_signal;
  logic       output_enable;
  logic [7:0] bus_out;

  int vectors     = 0;
  int miscompares = 0;

  sap_ram dut (
    .clk            (clk),
    .clear_addr_reg (clear_addr_reg),
    .dipswitch_data (dipswitch_data),
    .dipswitch_addr (dipswitch_addr),
    .bus_in         (bus_in),
    .addr_button    (addr_button),
    .prog_mode      (prog_mode),
    .load_addr_reg  (load_addr_reg),
    .write_enable   (write_enable),
    .control_signal (control_signal),
    .output_enable  (output_enable),
    .bus_out        (bus_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] exp);
    #1;
    vectors++;
    assert (bus_out === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, bus_out, exp);
    end
  endtask

  // Load the MAR from the dipswitches for one edge.
  task automatic load_dip(input logic [3:0] a);
    addr_button    = 1'b1;
    dipswitch_addr = a;
    load_addr_reg  = 1'b0;
    tick();
    load_addr_reg  = 1'b1;
  endtask

  initial begin
    clear_addr_reg = 1'b0;
    dipswitch_data = 8'h00;
    dipswitch_addr = 4'h0;
    bus_in         = 8'h00;
    addr_button    = 1'b0;
    prog_mode      = 1'b0;
    load_addr_reg  = 1'b1;
    write_enable   = 1'b1;
    control_signal = 1'b0;
    output_enable  = 1'b0;
    #2;

    // Reset: MAR=0, memory starts at zero.
    clear_addr_reg = 1'b1;
    tick();
    clear_addr_reg = 1'b0;
    check("reset_mem0", 8'h00);
    output_enable = 1'b1;
    check("reset_oe_high", 8'h00);
    output_enable = 1'b0;

    // Manual write after reset.
    dipswitch_data = 8'hCF;
    write_enable   = 1'b0;
    tick();
    write_enable   = 1'b1;
    check("manual_write_cf", 8'hCF);

    // Bus-sourced MAR load, then run-mode bus write.
    addr_button   = 1'b0;
    bus_in        = 8'h01;
    load_addr_reg = 1'b0;
    tick();
    load_addr_reg = 1'b1;
    check("bus_load_addr1_empty", 8'h00);
    prog_mode      = 1'b1;
    bus_in         = 8'hF7;
    control_signal = 1'b1;
    tick();
    control_signal = 1'b0;
    check("bus_write_f7", 8'hF7);
    bus_in        = 8'h00;
    load_addr_reg = 1'b0;
    tick();
    load_addr_reg = 1'b1;
    check("mem0_kept_cf", 8'hCF);
    prog_mode = 1'b0;

    // Load gating: address switch changes while load is high.
    load_dip(4'h1);
    check("dip_load_addr1", 8'hF7);
    dipswitch_addr = 4'h5;
    tick();
    tick();
    check("load_gated", 8'hF7);

    // Output gating.
    output_enable = 1'b1;
    check("oe_high_zero", 8'h00);
    output_enable = 1'b0;
    check("oe_low_restore", 8'hF7);

    // No write when write_enable=1 and control_signal=0, whatever else toggles.
    prog_mode      = 1'b1;
    bus_in         = 8'h3A;
    dipswitch_data = 8'h5C;
    tick();
    prog_mode      = 1'b0;
    tick();
    check("no_write_idle", 8'hF7);

    // Top address via bus; must not alias address 0.
    addr_button   = 1'b0;
    bus_in        = 8'h0F;
    load_addr_reg = 1'b0;
    tick();
    load_addr_reg  = 1'b1;
    prog_mode      = 1'b1;
    bus_in         = 8'h3C;
    control_signal = 1'b1;
    tick();
    control_signal = 1'b0;
    prog_mode      = 1'b0;
    check("addr15_write", 8'h3C);
    load_dip(4'h0);
    check("addr0_not_aliased", 8'hCF);

    // Reset priority over load, from MAR=5.
    load_dip(4'h5);
    check("addr5_empty", 8'h00);
    dipswitch_data = 8'h55;
    write_enable   = 1'b0;
    tick();
    write_enable   = 1'b1;
    check("addr5_write_55", 8'h55);
    dipswitch_addr = 4'h3;
    load_addr_reg  = 1'b0;
    clear_addr_reg = 1'b1;
    tick();
    clear_addr_reg = 1'b0;
    load_addr_reg  = 1'b1;
    check("reset_prio_mar0", CLR_MEM ? 8'h00 : 8'hCF);
    load_dip(4'h5);
    check("reset_keeps_addr5", CLR_MEM ? 8'h00 : 8'h55);
    load_dip(4'h1);
    check("reset_keeps_addr1", CLR_MEM ? 8'h00 : 8'hF7);

    // Write in the reset cycle lands at the pre-reset MAR (5).
    load_dip(4'h5);
    dipswitch_data = 8'h66;
    write_enable   = 1'b0;
    clear_addr_reg = 1'b1;
    tick();
    clear_addr_reg = 1'b0;
    write_enable   = 1'b1;
    check("reset_write_mar0", CLR_MEM ? 8'h00 : 8'hCF);
    load_dip(4'h5);
    check("reset_write_addr5", CLR_MEM ? 8'h00 : 8'h66);

    // Same-edge load and write: write to old MAR (2), then MAR=7.
    load_dip(4'h2);
    check("addr2_empty", 8'h00);
    dipswitch_addr = 4'h7;
    dipswitch_data = 8'hAA;
    load_addr_reg  = 1'b0;
    write_enable   = 1'b0;
    tick();
    load_addr_reg  = 1'b1;
    write_enable   = 1'b1;
    check("same_edge_mar7", 8'h00);
    load_dip(4'h2);
    check("same_edge_mem2_aa", 8'hAA);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_sap_ram
